// File: rtl/chan_downselect_pkg.sv
// Shared constants and types for the post-FFT channel down-select stage.
package chan_downselect_pkg;

    localparam int MAX_BINS   = 128;
    localparam int BIN_W      = 7;
    localparam int CFG_W      = 32;
    localparam int MASK_WORDS = 4;

    typedef logic [MAX_BINS-1:0] mask_t;

    localparam mask_t RESET_MASK = '1;

endpackage

// File: rtl/mask_hi_bin.sv
// Finds the highest enabled bin below the active FFT size; flags an empty
// selection so no output beat ever carries tlast for a dead mask.
module mask_hi_bin
    import chan_downselect_pkg::*;
(
    input  mask_t             mask,
    input  logic [7:0]        fft_size,
    output logic [BIN_W-1:0]  hi_bin,
    output logic              empty
);

    always_comb begin
        hi_bin = '0;
        empty  = 1'b1;
        // Ascending scan: the last match is the highest bin in range.
        for (int i = 0; i < MAX_BINS; i++) begin
            if (mask[i] && (i < int'(fft_size))) begin
                hi_bin = BIN_W'(i);
                empty  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/chan_downselect.sv
// Forwards only mask-selected FFT bins, tagging each with its bin index and
// marking the last selected bin of the frame with tlast.
module chan_downselect
    import chan_downselect_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CFG_W-1:0]  cfg_downselect_data,
    input  logic              cfg_downselect_update,
    input  logic              cfg_downselect_last,
    input  logic [7:0]        cfg_fft_size,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [BIN_W-1:0]  m_axis_tuser,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              mask_applied
);

    logic             upd_q;
    logic             upd_edge;
    logic [2:0]       word_ptr;
    logic             pending;
    mask_t            shadow_mask;
    mask_t            active_mask;
    logic [BIN_W-1:0] hi_bin;
    logic             hi_empty;
    logic [BIN_W-1:0] enc_hi_bin;
    logic             enc_empty;
    logic [BIN_W-1:0] bin_cnt;
    logic             accept;
    logic             commit;
    logic             bin_wrap;

    // Handshake: a beat transfers on a rising clk edge where valid && ready;
    // the output register accepts a new beat whenever it is empty or draining.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign upd_edge      = cfg_downselect_update ^ upd_q;
    assign commit        = pending && (bin_cnt == '0) && !accept;
    assign bin_wrap      = s_axis_tlast || ({1'b0, bin_cnt} == (cfg_fft_size - 8'd1));

    // Tracks the toggle line through reset so release never looks like an edge.
    always_ff @(posedge clk) begin
        upd_q <= cfg_downselect_update;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_ptr    <= '0;
            pending     <= 1'b0;
            shadow_mask <= RESET_MASK;
        end else begin
            if (upd_edge) begin
                if (word_ptr < 3'(MASK_WORDS)) begin
                    shadow_mask[CFG_W*word_ptr[1:0] +: CFG_W] <= cfg_downselect_data;
                    word_ptr <= word_ptr + 3'd1;
                end
                if (cfg_downselect_last) begin
                    word_ptr <= '0;
                end
            end
            if (upd_edge && cfg_downselect_last) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    mask_hi_bin u_hi_bin (
        .mask     (shadow_mask),
        .fft_size (cfg_fft_size),
        .hi_bin   (enc_hi_bin),
        .empty    (enc_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mask  <= RESET_MASK;
            hi_bin       <= BIN_W'(MAX_BINS - 1);
            hi_empty     <= 1'b0;
            mask_applied <= 1'b0;
        end else begin
            mask_applied <= commit;
            if (commit) begin
                active_mask <= shadow_mask;
                hi_bin      <= enc_hi_bin;
                hi_empty    <= enc_empty;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt <= '0;
        end else if (accept) begin
            bin_cnt <= bin_wrap ? '0 : bin_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept && active_mask[bin_cnt]) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= bin_cnt;
            m_axis_tlast  <= !hi_empty && (bin_cnt == hi_bin);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: doc/chan_downselect.md
Name: chan_downselect

Overview:
- Channelizer stage directly after the FFT; consumes one AXI-Stream beat per FFT bin.
- Forwards only the bins enabled in a 128-bit channel mask. Drops all other bins.
- The mask is loaded over the cfg_downselect register interface: 32-bit words, a toggle-strobe update, and a last flag.
- Output carries the bin index in tuser and asserts tlast on the final selected bin of each frame.

Parameters:
- DATA_W, 32, sample width (I/Q packed).
- MAX_BINS, 128, maximum FFT size and mask width.
- BIN_W, 7, log2(MAX_BINS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_downselect_data  in  32  mask word.
- cfg_downselect_update  in  1  toggle; every edge (0->1 or 1->0) writes one word.
- cfg_downselect_last  in  1  sampled with the update edge; marks the final word.
- cfg_fft_size  in  8  active bins per frame; power of two, 8..128.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tdata  in  DATA_W  input sample.
- s_axis_tlast  in  1  last bin of FFT frame.
- s_axis_tready  out  1  input ready.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tdata  out  DATA_W  output sample.
- m_axis_tuser  out  BIN_W  bin index of the output sample.
- m_axis_tlast  out  1  last selected bin of the frame.
- m_axis_tready  in  1  output ready.
- mask_applied  out  1  one-cycle pulse when a pending mask becomes active.

Behaviour:
- Reset values:
  - All outputs 0, except s_axis_tready = 1.
  - active_mask = all ones; shadow_mask = all ones.
  - hi_bin = 127; word_ptr = 0; pending = 0; bin_cnt = 0.
  - upd_q <= cfg_downselect_update sampled during reset, so no edge is detected on release.
- Config load:
  - Edge detect: upd_q registered each cycle; edge = update ^ upd_q.
  - On an edge: shadow_mask[32*word_ptr +: 32] <= data; word_ptr increments, saturating at 4. Words 5+ are discarded.
  - If last is sampled on the same edge: pending <= 1 and word_ptr <= 0.
  - Unwritten shadow words keep their previous contents.
  - A new load while pending = 1 overwrites the shadow; pending stays 1.
- Mask commit:
  - When pending = 1 and bin_cnt == 0 with no accepted beat this cycle (frame boundary or idle): active_mask <= shadow_mask, hi_bin <= encoder result, pending <= 0, mask_applied = 1.
  - Never committed mid-frame; a mid-frame load takes effect from the next frame.
- Bin counter:
  - Increments on each accepted input beat (s_axis_tvalid && s_axis_tready).
  - Wraps to 0 after cfg_fft_size-1, or after a beat with s_axis_tlast, whichever comes first.
  - tlast is a frame resync.
- Datapath: single output register, 1-cycle latency.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Accepted beat with active_mask[bin_cnt] = 1: load tdata, tuser = bin_cnt, tlast = (bin_cnt == hi_bin), tvalid = 1.
  - Accepted beat with mask bit 0: dropped. tvalid clears if the register is drained this cycle.
  - Output is held stable while tvalid && !tready.
- hi_bin: highest set bit of shadow_mask below cfg_fft_size. If none is set, the empty flag is stored.
  - Empty mask: all beats consumed, no output, no tlast.
  - cfg_fft_size change takes effect on hi_bin at the next commit only; software reloads the mask after a size change.
- Reset mid-frame: output beat discarded, counter to 0, partially loaded shadow lost, mask back to all ones.

Decomposition:
- Package chan_downselect_pkg: MAX_BINS, BIN_W, CFG_W = 32, MASK_WORDS = 4, RESET_MASK = all ones, typedef mask_t (logic [127:0]).
- Sub-module mask_hi_bin: combinational priority encoder. Inputs: mask_t, fft_size. Outputs: hi_bin, empty.

Test Plan:
- Load words 0x00000004, 0x00000003, 0x00000002, 0x00000001 (last on 4th), fft 128, full frame -> output bins 2, 32, 33, 65, 96; tlast only on 96; mask_applied pulses once before the frame.
- Load 0x00000001, 0, 0, 0x80000000 -> bins 0 and 127 output, tlast on 127. Same mask with cfg_fft_size = 64 and a reload -> only bin 0, with tlast.
- Load all zeros -> 128 beats consumed with s_axis_tready high throughout; m_axis_tvalid never asserts.
- Load all 0xFFFFFFFF mid-frame at bin 40 while the previous mask was bins {2, 96} -> current frame still outputs 2 and 96 only; next frame outputs all 128 bins, tlast on 127.
- m_axis_tready low for 5 cycles with mask all ones -> tdata/tuser held, s_axis_tready low, no beat lost or duplicated; tuser sequence is contiguous 0..127.
- Assert rst at bin 50 after 2 of 4 words loaded -> all outputs 0, the next frame passes all bins, and a fresh 4-word load applies correctly.
